// File: rtl/proc_control_unit.sv
// proc_control_unit
//   Decode-stage control unit. It decodes the 6-bit opcode into datapath
//   strobes and holds the process-mode state internally: exec/select flags,
//   the active process id, and the preemption quantum counter. It also runs
//   three sequences: the button handshake for in/out, the context switch,
//   and the return to the OS process.
//
// Ports
//   clock, reset_n         : single clock; asynchronous active-low reset
//   instr_valid, opcode    : instruction presented this cycle
//   pid_in                 : target process id, sampled with exec_prog
//   button                 : raw asynchronous user button
//   alu_code               : ALU operation, 5'b11111 = none
//   alu_en .. type_r       : datapath strobes (combinational)
//   halt                   : freeze PC and pipeline
//   exec_process, sel_reg_write, sel_reg_read, cur_pid : registered mode state
//   change_pc, end_proc    : one-cycle sequence pulses
//   dbg_state              : current FSM state, for observation
//
// Handshake: an instruction is consumed on a rising clock edge when
// instr_valid = 1 and the block is in RUN (or in IO_GO, for the held in/out).
// Strobes are only ever non-zero in those cycles; halt tells the datapath to
// hold the PC and keep opcode stable.
module proc_control_unit #(
  parameter int PID_W     = 2,
  parameter int QUANTUM   = 1000,
  parameter int QUANTUM_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             instr_valid,
  input  logic [5:0]       opcode,
  input  logic [PID_W-1:0] pid_in,
  input  logic             button,
  output logic [4:0]       alu_code,
  output logic             alu_en,
  output logic             branch,
  output logic             imm,
  output logic             in_sel,
  output logic             jal,
  output logic             jr,
  output logic             jump,
  output logic             reg_write,
  output logic             mem_write,
  output logic             use_stk,
  output logic             type_r,
  output logic             halt,
  output logic             exec_process,
  output logic             sel_reg_write,
  output logic             sel_reg_read,
  output logic [PID_W-1:0] cur_pid,
  output logic             change_pc,
  output logic             end_proc,
  output logic [2:0]       dbg_state
);

  localparam logic [5:0] OP_HALT      = 6'h01;
  localparam logic [5:0] OP_ADD       = 6'h02;
  localparam logic [5:0] OP_SUB       = 6'h03;
  localparam logic [5:0] OP_MULT      = 6'h04;
  localparam logic [5:0] OP_DIV       = 6'h05;
  localparam logic [5:0] OP_MOV       = 6'h06;
  localparam logic [5:0] OP_LW        = 6'h07;
  localparam logic [5:0] OP_SW        = 6'h08;
  localparam logic [5:0] OP_PUSH      = 6'h09;
  localparam logic [5:0] OP_POP       = 6'h0A;
  localparam logic [5:0] OP_IN        = 6'h0B;
  localparam logic [5:0] OP_OUT       = 6'h0C;
  localparam logic [5:0] OP_JR        = 6'h0D;
  localparam logic [5:0] OP_J         = 6'h0E;
  localparam logic [5:0] OP_JAL       = 6'h0F;
  localparam logic [5:0] OP_BEQ       = 6'h10;
  localparam logic [5:0] OP_BNEQ      = 6'h11;
  localparam logic [5:0] OP_SLT       = 6'h12;
  localparam logic [5:0] OP_SGT       = 6'h13;
  localparam logic [5:0] OP_ADDI      = 6'h14;
  localparam logic [5:0] OP_SUBI      = 6'h15;
  localparam logic [5:0] OP_LOADI     = 6'h16;
  localparam logic [5:0] OP_SLET      = 6'h17;
  localparam logic [5:0] OP_SGET      = 6'h18;
  localparam logic [5:0] OP_HALT_PROG = 6'h19;
  localparam logic [5:0] OP_EN_WRITE  = 6'h1A;
  localparam logic [5:0] OP_EN_READ   = 6'h1B;
  localparam logic [5:0] OP_DIS_READ  = 6'h1C;
  localparam logic [5:0] OP_DIS_WRITE = 6'h1D;
  localparam logic [5:0] OP_EXEC_PROG = 6'h1E;

  localparam logic [4:0] ALU_NONE = 5'b11111;

  localparam int unsigned          Q_LAST_I = (QUANTUM == 0) ? 0 : QUANTUM - 1;
  localparam logic [QUANTUM_W-1:0] Q_LAST   = QUANTUM_W'(Q_LAST_I);
  localparam logic                 Q_ON     = (QUANTUM != 0);

  // IO_GO is the single RUN-like cycle in which the held in/out executes.
  typedef enum logic [2:0] {
    S_RUN     = 3'd0,
    S_IO_WAIT = 3'd1,
    S_IO_GO   = 3'd2,
    S_SWITCH  = 3'd3,
    S_PREEMPT = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic                 exec_nxt, selw_nxt, selr_nxt;
  logic [PID_W-1:0]     pid_nxt;
  logic [QUANTUM_W-1:0] cnt, cnt_nxt;
  logic                 sync1, sync2, sync3;
  logic                 btn_rise;

  // Raw decode, before any gating.
  logic [4:0] d_alu;
  logic d_alu_en, d_branch, d_imm, d_in_sel, d_jal, d_jr, d_jump;
  logic d_reg_write, d_mem_write, d_use_stk, d_type_r, d_halt;

  always_comb begin
    d_alu       = ALU_NONE;
    d_alu_en    = 1'b0;
    d_branch    = 1'b0;
    d_imm       = 1'b0;
    d_in_sel    = 1'b0;
    d_jal       = 1'b0;
    d_jr        = 1'b0;
    d_jump      = 1'b0;
    d_reg_write = 1'b0;
    d_mem_write = 1'b0;
    d_use_stk   = 1'b0;
    d_type_r    = 1'b0;
    d_halt      = 1'b0;
    case (opcode)
      OP_HALT:  d_halt = 1'b1;
      OP_ADD:   begin d_alu = 5'd0; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_SUB:   begin d_alu = 5'd1; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_MULT:  begin d_alu = 5'd3; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_DIV:   begin d_alu = 5'd4; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_MOV:   begin d_alu = 5'd2; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_LW:    begin d_reg_write = 1'b1; d_imm = 1'b1; end
      OP_SW:    begin d_mem_write = 1'b1; d_imm = 1'b1; end
      OP_PUSH:  begin d_mem_write = 1'b1; d_use_stk = 1'b1; end
      OP_POP:   begin d_reg_write = 1'b1; d_use_stk = 1'b1; end
      OP_IN:    begin d_alu = 5'd5; d_alu_en = 1'b1; d_reg_write = 1'b1; d_in_sel = 1'b1; end
      // out routes the source register through the ALU as a move.
      OP_OUT:   begin d_alu = 5'd2; d_alu_en = 1'b1; end
      OP_JR:    d_jr = 1'b1;
      OP_J:     d_jump = 1'b1;
      OP_JAL:   begin d_jal = 1'b1; d_reg_write = 1'b1; end
      OP_BEQ:   begin d_alu = 5'd1; d_alu_en = 1'b1; d_branch = 1'b1; end
      OP_BNEQ:  begin d_alu = 5'd1; d_alu_en = 1'b1; d_branch = 1'b1; end
      OP_SLT:   begin d_alu = 5'd6; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_SGT:   begin d_alu = 5'd7; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_ADDI:  begin d_alu = 5'd0; d_alu_en = 1'b1; d_reg_write = 1'b1; d_imm = 1'b1; end
      OP_SUBI:  begin d_alu = 5'd1; d_alu_en = 1'b1; d_reg_write = 1'b1; d_imm = 1'b1; end
      OP_LOADI: begin d_alu = 5'd5; d_alu_en = 1'b1; d_reg_write = 1'b1; d_imm = 1'b1; end
      OP_SLET:  begin d_alu = 5'd8; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      OP_SGET:  begin d_alu = 5'd9; d_alu_en = 1'b1; d_reg_write = 1'b1; d_type_r = 1'b1; end
      default:  ;
    endcase
  end

  logic is_io, run_like, io_hold, expire;

  assign is_io    = (opcode == OP_IN) || (opcode == OP_OUT);
  assign run_like = instr_valid && ((state == S_RUN) || (state == S_IO_GO));
  // In RUN an in/out only parks the FSM; it executes in IO_GO.
  assign io_hold  = (state == S_RUN) && is_io;
  assign expire   = Q_ON && exec_process && instr_valid && (cnt == Q_LAST);

  always_comb begin
    alu_code  = ALU_NONE;
    alu_en    = 1'b0;
    branch    = 1'b0;
    imm       = 1'b0;
    in_sel    = 1'b0;
    jal       = 1'b0;
    jr        = 1'b0;
    jump      = 1'b0;
    reg_write = 1'b0;
    mem_write = 1'b0;
    use_stk   = 1'b0;
    type_r    = 1'b0;
    if (run_like && !io_hold) begin
      alu_code  = d_alu;
      alu_en    = d_alu_en;
      branch    = d_branch;
      imm       = d_imm;
      in_sel    = d_in_sel;
      jal       = d_jal;
      jr        = d_jr;
      jump      = d_jump;
      reg_write = d_reg_write;
      mem_write = d_mem_write;
      use_stk   = d_use_stk;
      type_r    = d_type_r;
    end
  end

  always_comb begin
    state_nxt = state;
    exec_nxt  = exec_process;
    selw_nxt  = sel_reg_write;
    selr_nxt  = sel_reg_read;
    pid_nxt   = cur_pid;
    cnt_nxt   = cnt;
    halt      = 1'b0;
    change_pc = 1'b0;
    end_proc  = 1'b0;
    case (state)
      S_RUN: begin
        halt = instr_valid && d_halt;
        if (instr_valid) begin
          if (opcode == OP_HALT_PROG || expire) begin
            // Preemption wins over every other effect of this instruction.
            state_nxt = S_PREEMPT;
            exec_nxt  = 1'b0;
            selw_nxt  = 1'b0;
            selr_nxt  = 1'b0;
            pid_nxt   = '0;
            cnt_nxt   = '0;
          end else if (is_io) begin
            state_nxt = S_IO_WAIT;
          end else if (opcode == OP_EXEC_PROG && !exec_process) begin
            state_nxt = S_SWITCH;
            exec_nxt  = 1'b1;
            selw_nxt  = 1'b1;
            selr_nxt  = 1'b1;
            pid_nxt   = pid_in;
            cnt_nxt   = '0;
          end else begin
            if (exec_process) cnt_nxt = cnt + QUANTUM_W'(1);
            case (opcode)
              OP_EN_WRITE:  selw_nxt = 1'b1;
              OP_EN_READ:   selr_nxt = 1'b1;
              OP_DIS_WRITE: begin selw_nxt = 1'b0; exec_nxt = 1'b0; end
              OP_DIS_READ:  begin selr_nxt = 1'b0; exec_nxt = 1'b0; end
              default: ;
            endcase
          end
        end
      end
      S_IO_WAIT: begin
        halt = 1'b1;
        if (btn_rise) state_nxt = S_IO_GO;
      end
      S_IO_GO: begin
        // The in/out completes here; the count for it is taken now.
        if (instr_valid && exec_process) cnt_nxt = cnt + QUANTUM_W'(1);
        state_nxt = S_RUN;
      end
      S_SWITCH: begin
        halt      = 1'b1;
        change_pc = 1'b1;
        state_nxt = S_RUN;
      end
      S_PREEMPT: begin
        halt      = 1'b1;
        end_proc  = 1'b1;
        state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_RUN;
      exec_process  <= 1'b0;
      sel_reg_write <= 1'b0;
      sel_reg_read  <= 1'b0;
      cur_pid       <= '0;
      cnt           <= '0;
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      sync3         <= 1'b0;
    end else begin
      state         <= state_nxt;
      exec_process  <= exec_nxt;
      sel_reg_write <= selw_nxt;
      sel_reg_read  <= selr_nxt;
      cur_pid       <= pid_nxt;
      cnt           <= cnt_nxt;
      sync1         <= button;
      sync2         <= sync1;
      sync3         <= sync2;
    end
  end

  // sync3 is the previous synchronised level, so a button already high on
  // entry to IO_WAIT never produces a rise.
  assign btn_rise  = sync2 && !sync3;
  assign dbg_state = state;

endmodule

// File: tb/tb_proc_control_unit.sv
module tb_proc_control_unit;

  logic       clock;
  logic       reset_n;
  logic       instr_valid;
  logic [5:0] opcode;
  logic [1:0] pid_in;
  logic       button;
  logic [4:0] alu_code;
  logic alu_en, branch, imm, in_sel, jal, jr, jump;
  logic reg_write, mem_write, use_stk, type_r;
  logic halt, exec_process, sel_reg_write, sel_reg_read;
  logic [1:0] cur_pid;
  logic change_pc, end_proc;
  logic [2:0] dbg_state;

  logic [10:0] strb;
  logic [2:0]  flags;
  assign strb  = {alu_en, branch, imm, in_sel, jal, jr, jump,
                  reg_write, mem_write, use_stk, type_r};
  assign flags = {exec_process, sel_reg_write, sel_reg_read};

  localparam logic [10:0] STB_ADD = 11'b100_0000_1001;
  localparam logic [10:0] STB_SW  = 11'b001_0000_0100;
  localparam logic [10:0] STB_BEQ = 11'b110_0000_0000;
  localparam logic [10:0] STB_IN  = 11'b100_1000_1000;

  proc_control_unit #(.PID_W(2), .QUANTUM(4), .QUANTUM_W(8)) dut (
    .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid),
    .opcode(opcode), .pid_in(pid_in), .button(button),
    .alu_code(alu_code), .alu_en(alu_en), .branch(branch), .imm(imm),
    .in_sel(in_sel), .jal(jal), .jr(jr), .jump(jump),
    .reg_write(reg_write), .mem_write(mem_write), .use_stk(use_stk),
    .type_r(type_r), .halt(halt), .exec_process(exec_process),
    .sel_reg_write(sel_reg_write), .sel_reg_read(sel_reg_read),
    .cur_pid(cur_pid), .change_pc(change_pc), .end_proc(end_proc),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard counters and checking task
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op);
    instr_valid = v;
    opcode      = op;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_strb"}, 32'(strb), 32'd0);
    check_eq({tag, "_alu"}, 32'(alu_code), 32'h1f);
    check_eq({tag, "_halt"}, 32'(halt), 32'd0);
    check_eq({tag, "_cpc"}, 32'(change_pc), 32'd0);
    check_eq({tag, "_endp"}, 32'(end_proc), 32'd0);
    check_eq({tag, "_flags"}, 32'(flags), 32'd0);
    check_eq({tag, "_pid"}, 32'(cur_pid), 32'd0);
  endtask

  int pulses;

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    opcode      = 6'h00;
    pid_in      = 2'd0;
    button      = 1'b0;
    #2;
    check_idle_outputs("por");
    step();
    step();
    reset_n = 1'b1;

    // Decode in RUN
    drive(1'b1, 6'h02);
    check_eq("add_strb", 32'(strb), 32'(STB_ADD));
    check_eq("add_alu", 32'(alu_code), 32'h00);
    drive(1'b1, 6'h08);
    check_eq("sw_strb", 32'(strb), 32'(STB_SW));
    drive(1'b1, 6'h10);
    check_eq("beq_strb", 32'(strb), 32'(STB_BEQ));
    check_eq("beq_alu", 32'(alu_code), 32'h01);
    drive(1'b1, 6'h12);
    check_eq("slt_alu", 32'(alu_code), 32'h06);
    drive(1'b1, 6'h3f);
    check_eq("unk_strb", 32'(strb), 32'd0);
    check_eq("unk_alu", 32'(alu_code), 32'h1f);
    drive(1'b1, 6'h01);
    check_eq("halt_lvl", 32'(halt), 32'd1);
    drive(1'b0, 6'h02);
    check_eq("novalid_strb", 32'(strb), 32'd0);
    check_eq("novalid_alu", 32'(alu_code), 32'h1f);

    // Context switch, then reset mid-stream
    pid_in = 2'd3;
    drive(1'b1, 6'h1e);
    step();
    check_eq("sw_cpc", 32'(change_pc), 32'd1);
    check_eq("sw_pid", 32'(cur_pid), 32'd3);
    check_eq("sw_flags", 32'(flags), 32'd7);
    check_eq("sw_halt", 32'(halt), 32'd1);
    drive(1'b0, 6'h00);
    step();
    check_eq("sw_after_cpc", 32'(change_pc), 32'd0);
    check_eq("sw_after_state", 32'(dbg_state), 32'd0);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    step();
    reset_n = 1'b1;

    // Button handshake with button already high on entry
    button = 1'b1;
    step();
    step();
    step();
    drive(1'b1, 6'h0b);
    check_eq("in_withheld", 32'(strb), 32'd0);
    step();
    for (int i = 0; i < 6; i++) step();
    check_eq("in_wait_halt", 32'(halt), 32'd1);
    check_eq("in_wait_strb", 32'(strb), 32'd0);
    button = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("in_low_halt", 32'(halt), 32'd1);
    button = 1'b1;
    step();
    check_eq("btn_e1_halt", 32'(halt), 32'd1);
    step();
    check_eq("btn_e2_halt", 32'(halt), 32'd1);
    step();
    check_eq("btn_e3_halt", 32'(halt), 32'd0);
    check_eq("btn_e3_strb", 32'(strb), 32'(STB_IN));
    check_eq("btn_e3_alu", 32'(alu_code), 32'h05);
    step();
    check_eq("btn_e4_strb", 32'(strb), 32'd0);
    check_eq("btn_e4_state", 32'(dbg_state), 32'd0);
    drive(1'b0, 6'h00);
    button = 1'b0;

    // Preemption after four adds
    pid_in = 2'd2;
    drive(1'b1, 6'h1e);
    step();
    drive(1'b1, 6'h02);
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("q_noend", 32'(end_proc), 32'd0);
    end
    step();
    check_eq("q_endp", 32'(end_proc), 32'd1);
    check_eq("q_pid", 32'(cur_pid), 32'd0);
    check_eq("q_flags", 32'(flags), 32'd0);
    drive(1'b0, 6'h00);
    step();
    check_eq("q_endp_off", 32'(end_proc), 32'd0);

    // halt_prog on the expiring instruction gives one pulse
    pid_in = 2'd1;
    drive(1'b1, 6'h1e);
    step();
    drive(1'b1, 6'h02);
    step();
    for (int i = 0; i < 3; i++) step();
    drive(1'b1, 6'h19);
    pulses = 0;
    step();
    drive(1'b0, 6'h00);
    for (int i = 0; i < 4; i++) begin
      if (end_proc) pulses++;
      step();
    end
    check_eq("hp_pulses", 32'(pulses), 32'd1);

    // exec_prog while already executing is a nop
    pid_in = 2'd1;
    drive(1'b1, 6'h1e);
    step();
    drive(1'b0, 6'h00);
    step();
    pid_in = 2'd3;
    drive(1'b1, 6'h1e);
    step();
    check_eq("ep_nop_cpc", 32'(change_pc), 32'd0);
    check_eq("ep_nop_pid", 32'(cur_pid), 32'd1);
    check_eq("ep_nop_state", 32'(dbg_state), 32'd0);

    // Flag ops
    drive(1'b1, 6'h1c);
    step();
    check_eq("dr1_flags", 32'(flags), 32'b010);
    drive(1'b1, 6'h1b);
    step();
    check_eq("er_read", 32'(sel_reg_read), 32'd1);
    drive(1'b1, 6'h1c);
    step();
    check_eq("dr2_read", 32'(sel_reg_read), 32'd0);
    check_eq("dr2_exec", 32'(exec_process), 32'd0);
    drive(1'b1, 6'h1d);
    step();
    check_eq("dw_flags", 32'(flags), 32'd0);

    // Reset during SWITCH
    pid_in = 2'd2;
    drive(1'b1, 6'h1e);
    step();
    check_eq("rs_cpc", 32'(change_pc), 32'd1);
    drive(1'b0, 6'h00);
    reset_n = 1'b0;
    #1;
    check_idle_outputs("rs");
    check_eq("rs_state", 32'(dbg_state), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check_eq("rs_after_cpc", 32'(change_pc), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
